// File: rtl/dcache_write_buffer.sv
// Posted-store buffer between the L1 D-cache write/miss port and the data-side AXI master.
// Optional store-to-load forwarding of buffered full-word writes when WBUF_FWD_EN is defined.
module dcache_write_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned TYPE_BITS = 3,
  parameter logic [TYPE_BITS-1:0] CACHE_WORD = TYPE_BITS'(2)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              d_req,
  input  logic                              d_write,
  input  logic [ADDR_BITS-1:0]              d_addr,
  input  logic [DATA_BITS-1:0]              d_in,
  input  logic [TYPE_BITS-1:0]              d_type,
  output logic [DATA_BITS-1:0]              d_out,
  output logic                              d_wait,
  output logic                              m_read,
  output logic                              m_write,
  output logic [ADDR_BITS-1:0]              m_addr,
  output logic [DATA_BITS-1:0]              m_data_in,
  output logic [TYPE_BITS-1:0]              m_write_type,
  input  logic [DATA_BITS-1:0]              m_data_out,
  input  logic                              m_stall,
  output logic                              wb_empty,
  output logic [$clog2(DEPTH):0]            wb_count
);
  localparam int unsigned PTR_BITS = $clog2(DEPTH);
  localparam int unsigned CNT_BITS = PTR_BITS + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;
  state_t state;

  logic [ADDR_BITS-1:0] buf_addr [DEPTH];
  logic [DATA_BITS-1:0] buf_data [DEPTH];
  logic [TYPE_BITS-1:0] buf_type [DEPTH];
  logic [PTR_BITS-1:0]  head, tail;
  logic [CNT_BITS-1:0]  count, count_next;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [TYPE_BITS-1:0] rd_type;
  logic                 has_space, push, pop;
  logic                 fwd_hit;
  logic [DATA_BITS-1:0] fwd_data;

  // Space is judged on the registered count, so a pop cannot free a slot for a same-cycle push.
  assign has_space  = (count < CNT_BITS'(DEPTH));
  assign push       = d_req & d_write & has_space;
  assign pop        = (state == DRAIN) & ~m_stall;
  assign count_next = count + CNT_BITS'(push) - CNT_BITS'(pop);

`ifdef WBUF_FWD_EN
  // Walk oldest to youngest so the last match seen is the youngest buffered write.
  always_comb begin
    logic [PTR_BITS-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head + PTR_BITS'(k);
      if ((CNT_BITS'(k) < count) &&
          (buf_addr[idx][ADDR_BITS-1:2] == d_addr[ADDR_BITS-1:2])) begin
        fwd_hit  = (buf_type[idx] == CACHE_WORD);
        fwd_data = buf_data[idx];
      end
    end
    if (!(d_req && !d_write && (state != READ))) begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
    end
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail] <= d_addr;
      buf_data[tail] <= d_in;
      buf_type[tail] <= d_type;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      rd_addr <= '0;
      rd_type <= '0;
    end else begin
      count <= count_next;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            state <= DRAIN;
          end else if (d_req && !d_write) begin
            rd_addr <= d_addr;
            rd_type <= d_type;
            state   <= READ;
          end
        end
        DRAIN: if (pop && (count_next == '0)) state <= IDLE;
        READ:  if (!m_stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_read       = 1'b0;
    m_write      = 1'b0;
    m_addr       = '0;
    m_data_in    = '0;
    m_write_type = '0;
    unique case (state)
      DRAIN: begin
        m_write      = 1'b1;
        m_addr       = buf_addr[head];
        m_data_in    = buf_data[head];
        m_write_type = buf_type[head];
      end
      READ: begin
        m_read       = 1'b1;
        m_addr       = rd_addr;
        m_write_type = rd_type;
      end
      default: ;
    endcase
  end

  always_comb begin
    d_wait = 1'b0;
    d_out  = '0;
    if (state == READ) d_out = m_data_out;
    else if (fwd_hit)  d_out = fwd_data;
    if (d_req && !rst) begin
      if (d_write)             d_wait = ~has_space;
      else if (state == READ)  d_wait = m_stall;
      else                     d_wait = ~fwd_hit;
    end
  end

  assign wb_empty = (count == '0) && (state == IDLE);
  assign wb_count = count;

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: program-order memory model plus write-order scoreboard.
module tb_dcache_write_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CB = $clog2(DEPTH) + 1;
  localparam logic [2:0] T_BYTE = 3'd0;
  localparam logic [2:0] T_WORD = 3'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          d_req, d_write;
  logic [31:0]   d_addr, d_in, d_out;
  logic [2:0]    d_type;
  logic          d_wait, m_read, m_write, m_stall, wb_empty;
  logic [31:0]   m_addr, m_data_in, m_data_out;
  logic [2:0]    m_write_type;
  logic [CB-1:0] wb_count;

  always #5 clk = ~clk;

  dcache_write_buffer #(
    .DEPTH(DEPTH), .ADDR_BITS(32), .DATA_BITS(32), .TYPE_BITS(3), .CACHE_WORD(T_WORD)
  ) dut (
    .clk(clk), .rst(rst), .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_in(d_in),
    .d_type(d_type), .d_out(d_out), .d_wait(d_wait), .m_read(m_read), .m_write(m_write),
    .m_addr(m_addr), .m_data_in(m_data_in), .m_write_type(m_write_type),
    .m_data_out(m_data_out), .m_stall(m_stall), .wb_empty(wb_empty), .wb_count(wb_count)
  );

  typedef struct packed { logic [31:0] a; logic [31:0] d; logic [2:0] t; } wr_t;
  wr_t         exp_w[$];
  wr_t         seen_w[$];
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] slave_mem [logic [31:0]];
  int          tests = 0;
  int          fails = 0;
  int          mcount = 0;
`ifdef WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          s_dwait, s_mread, s_mwrite, s_empty;
  logic [31:0]   s_dout;
  logic [CB-1:0] s_count;
  int            s_pending;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : dflt(a);
  endfunction
  function automatic int order_errors();
    int n;
    n = 0;
    if (seen_w.size() != exp_w.size()) n++;
    for (int i = 0; i < exp_w.size() && i < seen_w.size(); i++)
      if (seen_w[i] !== exp_w[i]) n++;
    return n;
  endfunction

  // One clock: drive, act as the master, sample, then advance the program-order model.
  task automatic tick(input logic req, input logic wr, input logic [31:0] a,
                      input logic [31:0] dat, input logic [2:0] ty, input logic stall);
    wr_t e;
    logic acc;
    @(negedge clk);
    d_req = req; d_write = wr; d_addr = a; d_in = dat; d_type = ty; m_stall = stall;
    #1;
    m_data_out = m_read ? slave_rd(m_addr) : 32'h0;
    #1;
    s_dwait = d_wait; s_dout = d_out; s_mread = m_read; s_mwrite = m_write;
    s_empty = wb_empty; s_count = wb_count; s_pending = mcount;
    if (!rst) begin
      acc = req && wr && (mcount < DEPTH);
      if (acc) begin
        e.a = a; e.d = dat; e.t = ty;
        exp_w.push_back(e);
        ref_mem[a] = dat;
      end
      if (m_write && !stall) begin
        e.a = m_addr; e.d = m_data_in; e.t = m_write_type;
        seen_w.push_back(e);
        slave_mem[m_addr] = m_data_in;
        mcount--;
      end
      if (acc) mcount++;
    end
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick(1'b0, 1'b0, 32'h0, 32'h0, T_WORD, 1'b0);
      if (s_empty) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_in = '0; d_type = '0;
    m_stall = 1'b0; m_data_out = '0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if ({m_read, m_write} !== 2'b00) begin fails++; $display("FAIL reset_mrw: got %b expected 00", {m_read, m_write}); end
    tests++; if (m_addr !== 32'h0) begin fails++; $display("FAIL reset_maddr: got %h expected 0", m_addr); end
    tests++; if ({d_wait, wb_empty} !== 2'b01) begin fails++; $display("FAIL reset_wait_empty: got %b expected 01", {d_wait, wb_empty}); end
    tests++; if (wb_count !== '0) begin fails++; $display("FAIL reset_count: got %0d expected 0", wb_count); end
    tests++; if (d_out !== 32'h0) begin fails++; $display("FAIL reset_dout: got %h expected 0", d_out); end
    rst = 1'b0;
    mcount = 0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 32'h100 + 32'(4 * i), 32'hA0 + 32'(i), T_WORD, 1'b0);
      tests++; if (s_dwait !== 1'b0) begin fails++; $display("FAIL b2b_wait%0d: got %b expected 0", i, s_dwait); end
    end
    drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b_empty: wb_empty never rose, got 0 expected 1"); end
    tests++; if (seen_w.size() !== 4) begin fails++; $display("FAIL b2b_nwrites: got %0d expected 4", seen_w.size()); end
    tests++; if (order_errors() !== 0) begin fails++; $display("FAIL b2b_order: got %0d mismatches expected 0", order_errors()); end
    exp_w.delete(); seen_w.delete();
  endtask

  task automatic test_full();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      tick(1'b1, 1'b1, 32'h180 + 32'(4 * i), $urandom, T_WORD, 1'b1);
      tests++; if (s_dwait !== 1'b0) begin fails++; $display("FAIL full_accept%0d: got %b expected 0", i, s_dwait); end
    end
    tick(1'b0, 1'b0, 32'h0, 32'h0, T_WORD, 1'b1);
    tests++; if (s_count !== CB'(4)) begin fails++; $display("FAIL full_count: got %0d expected 4", s_count); end
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 32'h190, 32'hF5F5_0005, T_WORD, 1'b1);
      tests++; if (s_dwait !== 1'b1) begin fails++; $display("FAIL full_block%0d: got %b expected 1", i, s_dwait); end
    end
    tick(1'b1, 1'b1, 32'h190, 32'hF5F5_0005, T_WORD, 1'b0);
    tests++; if ({s_dwait, s_mwrite} !== 2'b11) begin fails++; $display("FAIL full_popcycle: got %b expected 11", {s_dwait, s_mwrite}); end
    tick(1'b1, 1'b1, 32'h190, 32'hF5F5_0005, T_WORD, 1'b1);
    tests++; if (s_dwait !== 1'b0) begin fails++; $display("FAIL full_late_push: got %b expected 0", s_dwait); end
    tick(1'b0, 1'b0, 32'h0, 32'h0, T_WORD, 1'b1);
    tests++; if (s_count !== CB'(4)) begin fails++; $display("FAIL full_refill: got %0d expected 4", s_count); end
    drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL full_drain: got 0 expected 1"); end
    tests++; if (order_errors() !== 0) begin fails++; $display("FAIL full_order: got %0d mismatches expected 0", order_errors()); end
    exp_w.delete(); seen_w.delete();
  endtask

  task automatic test_read_order();
    bit done;
    int early;
    ref_mem[32'h200] = 32'hDEAD_BEEF;
    slave_mem[32'h200] = 32'hDEAD_BEEF;
    tick(1'b1, 1'b1, 32'h210, 32'h1111_0000, T_WORD, 1'b1);
    tick(1'b1, 1'b1, 32'h214, 32'h2222_0000, T_WORD, 1'b1);
    done = 1'b0; early = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick(1'b1, 1'b0, 32'h200, 32'h0, T_WORD, 1'($urandom_range(0, 1)));
      if (s_mread && s_pending > 0) early++;
      if (!s_dwait) done = 1'b1;
    end
    tests++; if (!done) begin fails++; $display("FAIL rd_done: d_wait stuck, got 1 expected 0"); end
    tests++; if (early !== 0) begin fails++; $display("FAIL rd_early: got %0d early m_read cycles expected 0", early); end
    tests++; if (s_dout !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", s_dout); end
    tests++; if (s_mread !== 1'b1) begin fails++; $display("FAIL rd_mread: got %b expected 1", s_mread); end
    tests++; if (seen_w.size() !== 2) begin fails++; $display("FAIL rd_writes_first: got %0d expected 2", seen_w.size()); end
    tick(1'b0, 1'b0, 32'h0, 32'h0, T_WORD, 1'b0);
    exp_w.delete(); seen_w.delete();
  endtask

  task automatic test_forward();
    bit done, ok;
    tick(1'b1, 1'b1, 32'h300, 32'h55AA, T_WORD, 1'b1);
    tick(1'b1, 1'b0, 32'h300, 32'h0, T_WORD, 1'b1);
    tests++; if (s_dwait !== !FWD) begin fails++; $display("FAIL fwd_wait: got %b expected %b", s_dwait, !FWD); end
    tests++; if (s_mread !== 1'b0) begin fails++; $display("FAIL fwd_mread: got %b expected 0", s_mread); end
    done = !s_dwait;
    for (int c = 0; c < 60 && !done; c++) begin
      tick(1'b1, 1'b0, 32'h300, 32'h0, T_WORD, 1'b0);
      if (!s_dwait) done = 1'b1;
    end
    tests++; if (s_dout !== 32'h55AA) begin fails++; $display("FAIL fwd_data: got %h expected 000055aa", s_dout); end
    drain(ok);
    tick(1'b1, 1'b1, 32'h300, 32'h77, T_BYTE, 1'b1);
    tick(1'b1, 1'b0, 32'h300, 32'h0, T_WORD, 1'b1);
    tests++; if (s_dwait !== 1'b1) begin fails++; $display("FAIL fwd_partial_wait: got %b expected 1", s_dwait); end
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick(1'b1, 1'b0, 32'h300, 32'h0, T_WORD, 1'b0);
      if (!s_dwait) done = 1'b1;
    end
    tests++; if (!(done && s_mread && s_pending == 0)) begin fails++; $display("FAIL fwd_partial_drain: got done=%b mread=%b pending=%0d expected 1 1 0", done, s_mread, s_pending); end
    tests++; if (s_dout !== 32'h77) begin fails++; $display("FAIL fwd_partial_data: got %h expected 00000077", s_dout); end
    drain(ok);
    tests++; if (order_errors() !== 0) begin fails++; $display("FAIL fwd_order: got %0d mismatches expected 0", order_errors()); end
    exp_w.delete(); seen_w.delete();
  endtask

  task automatic test_reset_mid_drain();
    bit ok;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 32'h380 + 32'(4 * i), $urandom, T_WORD, 1'b1);
    repeat (2) tick(1'b0, 1'b0, 32'h0, 32'h0, T_WORD, 1'b1);
    tests++; if ({s_count, s_mwrite} !== {CB'(3), 1'b1}) begin fails++; $display("FAIL rstd_pre: got count=%0d mwrite=%b expected 3 1", s_count, s_mwrite); end
    @(negedge clk);
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h384; m_stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    tests++; if ({m_read, m_write, d_wait} !== 3'b000) begin fails++; $display("FAIL rstd_ctl: got %b expected 000", {m_read, m_write, d_wait}); end
    tests++; if ({m_addr, m_data_in, m_write_type} !== '0) begin fails++; $display("FAIL rstd_mbus: got %h/%h/%h expected 0", m_addr, m_data_in, m_write_type); end
    tests++; if ({wb_empty, wb_count} !== {1'b1, CB'(0)}) begin fails++; $display("FAIL rstd_status: got empty=%b count=%0d expected 1 0", wb_empty, wb_count); end
    tests++; if (d_out !== 32'h0) begin fails++; $display("FAIL rstd_dout: got %h expected 0", d_out); end
    @(negedge clk);
    rst = 1'b0; d_req = 1'b0;
    mcount = 0; exp_w.delete(); seen_w.delete(); ref_mem = slave_mem;
    tick(1'b1, 1'b1, 32'h400, 32'h4444, T_WORD, 1'b0);
    drain(ok);
    tests++; if (seen_w.size() !== 1) begin fails++; $display("FAIL rstd_nwrites: got %0d expected 1", seen_w.size()); end
    else begin
      tests++; if (seen_w[0].a !== 32'h400) begin fails++; $display("FAIL rstd_first: got %h expected 00000400", seen_w[0].a); end
    end
    exp_w.delete(); seen_w.delete();
  endtask

  task automatic test_random();
    bit done, ok, exp_wait;
    logic [31:0] a, d, want;
    logic [2:0]  ty;
    for (int op = 0; op < 150; op++) begin
      a = 32'h500 + 32'(4 * $urandom_range(0, 3));
      if ($urandom_range(0, 9) < 6) begin
        d = $urandom; ty = 3'($urandom_range(0, 2));
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
          exp_wait = (mcount >= DEPTH);
          tick(1'b1, 1'b1, a, d, ty, 1'($urandom_range(0, 1)));
          tests++; if (s_dwait !== exp_wait) begin fails++; $display("FAIL rnd_wr_wait op%0d: got %b expected %b", op, s_dwait, exp_wait); end
          tests++; if (s_count !== CB'(s_pending)) begin fails++; $display("FAIL rnd_count op%0d: got %0d expected %0d", op, s_count, s_pending); end
          if (!exp_wait) done = 1'b1;
        end
        tests++; if (!done) begin fails++; $display("FAIL rnd_wr_timeout op%0d: got stuck expected accept", op); end
      end else if ($urandom_range(0, 3) != 0) begin
        want = ref_rd(a);
        done = 1'b0;
        for (int c = 0; c < 80 && !done; c++) begin
          tick(1'b1, 1'b0, a, 32'h0, T_WORD, 1'($urandom_range(0, 1)));
          tests++; if (s_mread && s_pending > 0) begin fails++; $display("FAIL rnd_rd_order op%0d: got m_read with %0d pending expected 0", op, s_pending); end
          if (!s_dwait) done = 1'b1;
        end
        tests++; if (!done) begin fails++; $display("FAIL rnd_rd_timeout op%0d: got stuck expected completion", op); end
        tests++; if (s_dout !== want) begin fails++; $display("FAIL rnd_rd_data op%0d: got %h expected %h", op, s_dout, want); end
      end else begin
        tick(1'b0, 1'b0, 32'h0, 32'h0, T_WORD, 1'($urandom_range(0, 1)));
      end
    end
    drain(ok);
    tests++; if (!ok) begin fails++; $display("FAIL rnd_drain: got 0 expected 1"); end
    tests++; if (order_errors() !== 0) begin fails++; $display("FAIL rnd_order: got %0d mismatches expected 0", order_errors()); end
    exp_w.delete(); seen_w.delete();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_read_order();
    test_forward();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dcache_write_buffer.md
Name: dcache_write_buffer

Overview:
- Posted-store buffer between the L1 data cache miss/write-through port (D_* side) and the data-side AXI master (M1 side).
- Accepts cache write requests into a DEPTH-entry FIFO with zero wait, then drains them to the master in order.
- Read requests are issued to the master only after all older buffered writes have completed, preserving program order to memory.

Parameters:
- DEPTH, 4, number of buffered writes; power of 2, at least 2.
- ADDR_BITS, 32, address width.
- DATA_BITS, 32, data width.
- TYPE_BITS, 3, access-type width; encoding per def.svh CACHE_* (CACHE_WORD = full word).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- d_req  in  1  cache request; held stable until d_wait low
- d_write  in  1  1 = write, 0 = read
- d_addr  in  ADDR_BITS  byte address
- d_in  in  DATA_BITS  write data
- d_type  in  TYPE_BITS  access type
- d_out  out  DATA_BITS  read data, valid when d_req & ~d_write & ~d_wait
- d_wait  out  1  request not yet complete
- m_read  out  1  read request to master
- m_write  out  1  write request to master
- m_addr  out  ADDR_BITS  master address
- m_data_in  out  DATA_BITS  master write data
- m_write_type  out  TYPE_BITS  master access type
- m_data_out  in  DATA_BITS  master read data
- m_stall  in  1  master busy; a transaction completes in the cycle (m_read|m_write) & ~m_stall
- wb_empty  out  1  FIFO empty and no transaction outstanding
- wb_count  out  $clog2(DEPTH)+1  buffered entry count

Behaviour:
- FIFO
  - Entries {addr, data, type}; head/tail pointers wrap modulo DEPTH.
  - Count is updated by push minus pop; a simultaneous push and pop leaves count unchanged.
- Write accept
  - d_req & d_write & (count < DEPTH) pushes in that cycle; d_wait = 0 in that cycle (combinational).
  - When full, d_wait = 1 and no push occurs. A pop that cycle does not allow a same-cycle push; the push happens the next cycle.
- FSM states: IDLE, DRAIN, READ.
- IDLE
  - If count > 0, go to DRAIN.
  - Else, if d_req & ~d_write, latch d_addr/d_type into rd_addr/rd_type and go to READ.
- DRAIN
  - m_write = 1, with m_addr/m_data_in/m_write_type taken from the head entry.
  - On completion: pop. If count after the pop is 0, go to IDLE; otherwise stay in DRAIN and present the next head the following cycle.
- READ
  - m_read = 1, with m_addr = rd_addr and m_write_type = rd_type.
  - d_wait = m_stall; d_out = m_data_out passes through in this state.
  - On completion, go to IDLE.
- Read while writes are pending
  - d_wait = 1 until the FIFO drains and the READ completes.
  - Minimum read latency from an empty buffer: one IDLE cycle, then master latency.
- Idle outputs: in IDLE, m_read/m_write = 0 and m_addr/m_data_in/m_write_type = 0.
- d_wait rules
  - d_wait = 0 when d_req = 0.
  - For a read outside READ state, d_wait = 1 (except the forwarding case below).
- wb_empty = (count == 0) & (state == IDLE).
- Reset (any time, including mid-drain or mid-read)
  - state = IDLE, pointers and count = 0, buffered data discarded.
  - All m_* outputs = 0, d_wait = 0, d_out = 0, wb_empty = 1, wb_count = 0.
  - The master is reset by the same rst.

Optional Feature:
- Macro: WBUF_FWD_EN.
- Defined:
  - In IDLE or DRAIN, a read whose word address (addr[ADDR_BITS-1:2]) matches the youngest matching buffered entry with type CACHE_WORD returns that entry's data on d_out with d_wait = 0 in the same cycle. No master read is issued.
  - If the youngest match is a partial (byte/half) write, the read waits for the full drain as usual.
  - If no entry matches, the read waits for the full drain as usual.
- Undefined: no address compare logic; every read waits for the full drain.

Test Plan:
- Reset, then four writes (addr 0x100/0x104/0x108/0x10C, data 0xA0..0xA3) back-to-back with m_stall = 0 → d_wait = 0 on all four; m_write issues in the same order; wb_empty = 1 after the fourth completion.
- m_stall = 1, five writes → first four accepted (wb_count = 4); fifth sees d_wait = 1 until the first master completion, then is accepted the next cycle.
- Two writes buffered, then a read of 0x200 with master returning 0xDEADBEEF → m_read is not asserted before the second write completes; d_out = 0xDEADBEEF with d_wait falling in the completion cycle.
- WBUF_FWD_EN, word write 0x55AA to 0x300 held in the buffer by m_stall = 1, then read 0x300 → d_out = 0x55AA with d_wait = 0 the same cycle and no m_read. Repeating with a byte write to 0x300 → the read waits for the drain.
- rst asserted mid-DRAIN with wb_count = 3 → all outputs reach their reset values immediately; after release, a new write to 0x400 is the first m_write issued.
